// File: rtl/sphere_pkg.sv
// rtl/sphere_pkg.sv - shared constants, driver state and point-entry types for the sphere generator path
package sphere_pkg;

    localparam logic [31:0] FP_ONE     = 32'h0001_0000;
    localparam logic [31:0] FP_NEG_ONE = 32'hFFFF_0000;

    localparam logic [1:0] BASE_2 = 2'b00;
    localparam logic [1:0] BASE_3 = 2'b01;
    localparam logic [1:0] BASE_7 = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DONE = 2'd2
    } drv_state_e;

    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] z;
        logic [31:0] k;
        logic        last;
    } pt_entry_t;

    localparam int PT_W = $bits(pt_entry_t);

endpackage

// File: rtl/sphere_pt_fifo.sv
// rtl/sphere_pt_fifo.sv - first-word fall-through point FIFO with count and held head when empty
module sphere_pt_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 129
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     valid_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] hold_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push_i && (count_q != CW'(DEPTH));
    assign do_pop  = pop_i && (count_q != '0);
    assign valid_o = (count_q != '0);
    assign count_o = count_q;
    // When empty the outputs keep showing the most recently popped entry.
    assign rdata_o = valid_o ? mem_q[rd_ptr_q] : hold_q;

    // Storage array; contents are only observable once written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers wrap naturally (power-of-two depth); count tracks occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            hold_q   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                hold_q   <= mem_q[rd_ptr_q];
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/sphere_seq_driver.sv
// rtl/sphere_seq_driver.sv - sequences generator requests for a command and streams tagged points out
module sphere_seq_driver
    import sphere_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [31:0]      cmd_k_start,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [1:0]       cmd_base0,
    input  logic [1:0]       cmd_base1,
    output logic             gen_start,
    output logic [31:0]      gen_k,
    output logic [1:0]       gen_base_sel0,
    output logic [1:0]       gen_base_sel1,
    input  logic             gen_ready,
    input  logic             gen_done,
    input  logic [31:0]      gen_x,
    input  logic [31:0]      gen_y,
    input  logic [31:0]      gen_z,
    output logic             pt_valid,
    input  logic             pt_ready,
    output logic [31:0]      pt_x,
    output logic [31:0]      pt_y,
    output logic [31:0]      pt_z,
    output logic [31:0]      pt_k,
    output logic             pt_last,
    output logic             busy
);

    localparam int FCW = $clog2(FIFO_DEPTH) + 1;

    drv_state_e       state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [31:0]      k_q, k_d;
    logic [1:0]       b0_q, b0_d;
    logic [1:0]       b1_q, b1_d;
    logic             start;
    logic             push;
    pt_entry_t        push_entry;
    pt_entry_t        head;
    logic [FCW-1:0]   fifo_count;

    // Next-state and strobes; ISSUE only fires once a FIFO slot is guaranteed for the result.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        k_d     = k_q;
        b0_d    = b0_q;
        b1_d    = b1_q;
        start   = 1'b0;
        push    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    k_d   = cmd_k_start;
                    rem_d = cmd_count;
                    b0_d  = cmd_base0;
                    b1_d  = cmd_base1;
                    if (cmd_count != '0) begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (gen_ready && (fifo_count < FCW'(FIFO_DEPTH))) begin
                    start   = 1'b1;
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (gen_done) begin
                    push    = 1'b1;
                    rem_d   = rem_q - 1'b1;
                    k_d     = k_q + 32'd1;
                    state_d = (rem_q == CNT_W'(1)) ? ST_IDLE : ST_ISSUE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Driver state and latched command context.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            k_q     <= '0;
            b0_q    <= '0;
            b1_q    <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            k_q     <= k_d;
            b0_q    <= b0_d;
            b1_q    <= b1_d;
        end
    end

    assign push_entry = '{x: gen_x, y: gen_y, z: gen_z, k: k_q, last: (rem_q == CNT_W'(1))};

    sphere_pt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PT_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .wdata_i (push_entry),
        .pop_i   (pt_valid & pt_ready),
        .rdata_o (head),
        .valid_o (pt_valid),
        .count_o (fifo_count)
    );

    assign cmd_ready     = (state_q == ST_IDLE);
    assign gen_start     = start;
    assign gen_k         = k_q;
    assign gen_base_sel0 = b0_q;
    assign gen_base_sel1 = b1_q;
    assign pt_x          = head.x;
    assign pt_y          = head.y;
    assign pt_z          = head.z;
    assign pt_k          = head.k;
    assign pt_last       = head.last;
    assign busy          = (state_q != ST_IDLE) | pt_valid;

endmodule

// File: tb/tb_sphere_seq_driver.sv
// tb/tb_sphere_seq_driver.sv - randomized self-checking bench for sphere_seq_driver
module tb_sphere_seq_driver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_k_start = '0;
    logic [15:0] cmd_count = '0;
    logic [1:0]  cmd_base0 = '0;
    logic [1:0]  cmd_base1 = '0;
    logic        gen_start;
    logic [31:0] gen_k;
    logic [1:0]  gen_base_sel0;
    logic [1:0]  gen_base_sel1;
    logic        gen_ready = 1'b1;
    logic        gen_done = 1'b0;
    logic [31:0] gen_x = '0;
    logic [31:0] gen_y = '0;
    logic [31:0] gen_z = '0;
    logic        pt_valid;
    logic        pt_ready = 1'b0;
    logic [31:0] pt_x;
    logic [31:0] pt_y;
    logic [31:0] pt_z;
    logic [31:0] pt_k;
    logic        pt_last;
    logic        busy;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int starts = 0;
    int last_done_cyc = -100;
    int hold_cycles = 1;
    int lat_lo = 1;
    int lat_hi = 3;
    int g_lat = 0;
    int g_hold = 0;
    bit g_inflight = 0;
    bit ignore_k = 0;
    bit rand_ready = 0;
    logic start_seen = 1'b0;
    logic [31:0] k_seen = '0;
    logic [31:0] kcap = '0;
    logic [1:0] cur_b0 = '0;
    logic [1:0] cur_b1 = '0;

    typedef struct {
        logic [31:0] k;
        logic        last;
    } exp_t;
    exp_t exp_q[$];

    sphere_seq_driver #(.FIFO_DEPTH(4), .CNT_W(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_k_start   (cmd_k_start),
        .cmd_count     (cmd_count),
        .cmd_base0     (cmd_base0),
        .cmd_base1     (cmd_base1),
        .gen_start     (gen_start),
        .gen_k         (gen_k),
        .gen_base_sel0 (gen_base_sel0),
        .gen_base_sel1 (gen_base_sel1),
        .gen_ready     (gen_ready),
        .gen_done      (gen_done),
        .gen_x         (gen_x),
        .gen_y         (gen_y),
        .gen_z         (gen_z),
        .pt_valid      (pt_valid),
        .pt_ready      (pt_ready),
        .pt_x          (pt_x),
        .pt_y          (pt_y),
        .pt_z          (pt_z),
        .pt_k          (pt_k),
        .pt_last       (pt_last),
        .busy          (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Generator result model: z = cos(phi) = 2*vdc2(k) - 1 in 16.16; x, y are arbitrary functions of k.
    function automatic logic [31:0] fz(input logic [31:0] k);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[i] = k[15-i];
        return ({16'h0, r} << 1) - 32'h0001_0000;
    endfunction
    function automatic logic [31:0] fx(input logic [31:0] k);
        return k * 32'd7 + 32'd1;
    endfunction
    function automatic logic [31:0] fy(input logic [31:0] k);
        return {k[15:0], k[31:16]} ^ 32'h5A5A_A5A5;
    endfunction

    // Generator handshake model: sample at negedge, respond just after posedge.
    initial begin
        forever begin
            @(negedge clk);
            start_seen = gen_start & rst_n;
            k_seen = gen_k;
            @(posedge clk);
            #1;
            gen_done = 1'b0;
            if (rand_ready) pt_ready = 1'($urandom_range(0, 1));
            if (start_seen) begin
                g_inflight = 1;
                g_lat = $urandom_range(lat_lo, lat_hi);
                gen_ready = 1'b0;
                kcap = k_seen;
                ignore_k = 0;
            end else if (g_inflight) begin
                g_lat--;
                if (g_lat == 0) begin
                    gen_done = 1'b1;
                    gen_x = fx(kcap);
                    gen_y = fy(kcap);
                    gen_z = fz(kcap);
                    g_inflight = 0;
                    g_hold = hold_cycles;
                end
            end else if (!gen_ready) begin
                if (g_hold == 0) gen_ready = 1'b1;
                else g_hold--;
            end
        end
    end

    // Protocol checks and point scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (gen_start) begin
                starts++;
                total++;
                if (gen_ready !== 1'b1 || gen_base_sel0 !== cur_b0 || gen_base_sel1 !== cur_b1 ||
                    (cyc - last_done_cyc) < hold_cycles + 1) begin
                    bad++;
                    $display("FAIL gen_start_protocol: ready=%b b0=%b b1=%b gap=%0d, need ready=1 b0=%b b1=%b gap>=%0d",
                             gen_ready, gen_base_sel0, gen_base_sel1, cyc - last_done_cyc, cur_b0, cur_b1, hold_cycles + 1);
                end
            end
            if (gen_done) last_done_cyc = cyc;
            if ((g_inflight || gen_done) && !ignore_k) begin
                total++;
                if (gen_k !== kcap) begin
                    bad++;
                    $display("FAIL gen_k_stable: gen_k=%h, need %h", gen_k, kcap);
                end
            end
            if (pt_valid && pt_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_point: pt_k=%h, need no point", pt_k);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (pt_k !== e.k || pt_last !== e.last || pt_x !== fx(e.k) || pt_y !== fy(e.k) || pt_z !== fz(e.k)) begin
                        bad++;
                        $display("FAIL point: k=%h last=%b x=%h y=%h z=%h, need k=%h last=%b x=%h y=%h z=%h",
                                 pt_k, pt_last, pt_x, pt_y, pt_z, e.k, e.last, fx(e.k), fy(e.k), fz(e.k));
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, need completion");
        $fatal(1);
    end

    task automatic issue(input logic [31:0] k, input logic [15:0] n, input logic [1:0] b0, input logic [1:0] b1);
        bit ok = 0;
        @(posedge clk);
        #1;
        cmd_k_start = k;
        cmd_count = n;
        cmd_base0 = b0;
        cmd_base1 = b1;
        cmd_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1;
                break;
            end
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cur_b0 = b0;
        cur_b1 = b1;
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL cmd_accept: cmd_ready=%b, need 1 within 300 cycles", cmd_ready);
        end else begin
            for (int i = 0; i < int'(n); i++) begin
                exp_t e;
                e.k = k + 32'(i);
                e.last = (i == int'(n) - 1);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic wait_drain();
        bit ok = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy && !g_inflight && gen_ready) begin
                ok = 1;
                break;
            end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL drain: pending=%0d busy=%b, need 0 and 0", exp_q.size(), busy);
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({cmd_ready, gen_start, gen_k, gen_base_sel0, gen_base_sel1} !== {1'b1, 1'b0, 32'd0, 2'd0, 2'd0}) begin
            bad++;
            $display("FAIL reset_ctrl: rdy=%b start=%b k=%h b0=%b b1=%b, need 1 0 0 0 0",
                     cmd_ready, gen_start, gen_k, gen_base_sel0, gen_base_sel1);
        end
        total++;
        if ({pt_valid, pt_x, pt_y, pt_z, pt_k, pt_last, busy} !== '0) begin
            bad++;
            $display("FAIL reset_pt: valid=%b x=%h y=%h z=%h k=%h last=%b busy=%b, need all 0",
                     pt_valid, pt_x, pt_y, pt_z, pt_k, pt_last, busy);
        end
        @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    task automatic test_run();
        bit seen;
        pt_ready = 1'b1;
        issue(32'd1, 16'd3, 2'b00, 2'b01);
        for (int i = 0; i < 3; i++) begin
            seen = 0;
            for (int c = 0; c < 50; c++) begin
                if (gen_done) begin
                    seen = 1;
                    break;
                end
                @(negedge clk);
            end
            @(negedge clk);
            total++;
            if (!seen || pt_valid !== 1'b1 || pt_k !== 32'(i + 1) || pt_last !== (i == 2)) begin
                bad++;
                $display("FAIL run_latency[%0d]: done=%b valid=%b k=%h last=%b, need 1 1 %h %b",
                         i, seen, pt_valid, pt_k, pt_last, 32'(i + 1), (i == 2));
            end
            if (i == 0) begin
                total++;
                if (pt_z !== 32'h0) begin
                    bad++;
                    $display("FAIL run_z_k1: pt_z=%h, need 00000000", pt_z);
                end
            end
            if (i == 2) begin
                total++;
                if (cmd_ready !== 1'b1) begin
                    bad++;
                    $display("FAIL run_cmd_ready: cmd_ready=%b, need 1", cmd_ready);
                end
            end
        end
        wait_drain();
    endtask

    task automatic test_backpressure();
        pt_ready = 1'b0;
        starts = 0;
        issue($urandom, 16'd6, 2'b10, 2'b00);
        repeat (40) @(negedge clk);
        total++;
        if (starts !== 4 || pt_valid !== 1'b1 || cmd_ready !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL bp_stall: starts=%0d valid=%b rdy=%b busy=%b, need 4 1 0 1", starts, pt_valid, cmd_ready, busy);
        end
        for (int j = 0; j < 2; j++) begin
            @(posedge clk);
            #1;
            pt_ready = 1'b1;
            @(posedge clk);
            #1;
            pt_ready = 1'b0;
            repeat (20) @(negedge clk);
            total++;
            if (starts !== 5 + j) begin
                bad++;
                $display("FAIL bp_pop[%0d]: starts=%0d, need %0d", j, starts, 5 + j);
            end
        end
        pt_ready = 1'b1;
        wait_drain();
        total++;
        if (starts !== 6) begin
            bad++;
            $display("FAIL bp_total: starts=%0d, need 6", starts);
        end
    endtask

    task automatic test_wrap();
        pt_ready = 1'b1;
        issue(32'hFFFF_FFFF, 16'd2, 2'b01, 2'b10);
        wait_drain();
    endtask

    task automatic test_zero_count();
        starts = 0;
        issue($urandom, 16'd0, 2'b00, 2'b00);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++;
            if (cmd_ready !== 1'b1 || pt_valid !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL zero_count[%0d]: rdy=%b valid=%b busy=%b, need 1 0 0", i, cmd_ready, pt_valid, busy);
            end
        end
        total++;
        if (starts !== 0) begin
            bad++;
            $display("FAIL zero_count_starts: starts=%0d, need 0", starts);
        end
    endtask

    task automatic test_handshake();
        hold_cycles = 5;
        pt_ready = 1'b1;
        issue($urandom, 16'd3, 2'b01, 2'b01);
        wait_drain();
        hold_cycles = 1;
    endtask

    task automatic test_back_to_back();
        rand_ready = 1;
        for (int c = 0; c < 8; c++) begin
            issue($urandom, 16'($urandom_range(1, 7)), 2'($urandom_range(0, 2)), 2'($urandom_range(0, 2)));
        end
        wait_drain();
        rand_ready = 0;
        pt_ready = 1'b1;
    endtask

    task automatic test_reset_midrun();
        bit ok = 0;
        bit late = 0;
        pt_ready = 1'b0;
        lat_lo = 6;
        lat_hi = 6;
        starts = 0;
        issue($urandom, 16'd6, 2'b10, 2'b10);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (starts == 3 && g_inflight) begin
                ok = 1;
                break;
            end
        end
        ignore_k = 1;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        total++;
        if (!ok || {cmd_ready, gen_start, gen_k, gen_base_sel0, gen_base_sel1} !== {1'b1, 1'b0, 32'd0, 2'd0, 2'd0}) begin
            bad++;
            $display("FAIL midrun_reset_ctrl: reached=%b rdy=%b start=%b k=%h b0=%b b1=%b, need 1 1 0 0 0 0",
                     ok, cmd_ready, gen_start, gen_k, gen_base_sel0, gen_base_sel1);
        end
        total++;
        if ({pt_valid, pt_x, pt_y, pt_z, pt_k, pt_last, busy} !== '0) begin
            bad++;
            $display("FAIL midrun_reset_pt: valid=%b k=%h last=%b busy=%b, need all 0", pt_valid, pt_k, pt_last, busy);
        end
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        pt_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (gen_done) late = 1;
        end
        total++;
        if (!late || pt_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL midrun_late_done: late_done=%b valid=%b busy=%b, need 1 0 0", late, pt_valid, busy);
        end
        lat_lo = 1;
        lat_hi = 3;
        wait_drain();
    endtask

    initial begin
        test_reset();
        test_run();
        test_backpressure();
        test_wrap();
        test_zero_count();
        test_handshake();
        test_back_to_back();
        test_reset_midrun();
        test_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
